// File: rtl/sum_bcd_display.sv
`timescale 1ns/1ps
// sum_bcd_display
//   Converts the 9-bit carry-lookahead adder result {co, s[7:0]} to packed BCD
//   with a serial double-dabble engine (one bit per clock). The result is also
//   registered as seven-segment patterns for the board displays. Leading zeros
//   can optionally be blanked. A valid/ready handshake accepts one value at a time.
//
//   Configurations where 10^DIGITS <= 2^WIDTH-1 are illegal and unsupported.
//
// Ports
//   hz100     in   system clock
//   reset     in   synchronous, active-high reset
//   in_valid  in   in_value holds a result to convert
//   in_value  in   [WIDTH-1:0] unsigned binary value
//   in_ready  out  a value can be accepted this cycle (not converting)
//   busy      out  conversion in progress
//   out_valid out  bcd/seg hold the conversion of the last accepted value
//   bcd       out  [4*DIGITS-1:0] packed BCD, ones digit in [3:0]
//   seg       out  [8*DIGITS-1:0] segment patterns, ones digit in [7:0],
//                  bit0=a .. bit6=g, bit7=dp, active-high
module sum_bcd_display #(
    parameter int WIDTH         = 9,
    parameter int DIGITS        = 3,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  hz100,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_value,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [8*DIGITS-1:0]   seg
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       count_q, count_d;
    logic                busy_q, busy_d;
    logic                out_valid_q, out_valid_d;
    logic [SW-1:0]       bcd_q, bcd_d;
    logic [8*DIGITS-1:0] seg_q, seg_d;

    // Double-dabble step results, computed from the current scratch/binary.
    logic [SW-1:0]       scratch_adj;
    logic [SW-1:0]       scratch_step;
    logic [WIDTH-1:0]    bin_step;
    logic [8*DIGITS-1:0] seg_step;

    logic transfer;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] pattern;
        case (digit)
            4'd0:    pattern = 8'h3F;
            4'd1:    pattern = 8'h06;
            4'd2:    pattern = 8'h5B;
            4'd3:    pattern = 8'h4F;
            4'd4:    pattern = 8'h66;
            4'd5:    pattern = 8'h6D;
            4'd6:    pattern = 8'h7D;
            4'd7:    pattern = 8'h07;
            4'd8:    pattern = 8'h7F;
            4'd9:    pattern = 8'h67;
            default: pattern = 8'h00; // non-BCD codes go dark
        endcase
        return pattern;
    endfunction

    assign in_ready  = (state_q != CONVERT);
    assign transfer  = in_valid && in_ready;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign seg       = seg_q;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift the
    // combined {scratch, binary} register left by one.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = 4'(scratch_q[4*i +: 4] + 4'd3);
        end
        scratch_step = {scratch_adj[SW-2:0], bin_q[WIDTH-1]};
        bin_step     = {bin_q[WIDTH-2:0], 1'b0};
    end

    // Segment patterns for the value the final step produces. Scanning from
    // the most significant digit, a digit stays blank while every digit above
    // it (and itself) is zero; the ones digit is always shown.
    always_comb begin
        logic leading;
        leading  = 1'b1;
        seg_step = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (BLANK_LEADING && (i > 0) && leading && (scratch_step[4*i +: 4] == 4'd0))
                seg_step[8*i +: 8] = 8'h00;
            else
                seg_step[8*i +: 8] = seg_encode(scratch_step[4*i +: 4]);
            if (scratch_step[4*i +: 4] != 4'd0)
                leading = 1'b0;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        bin_d       = bin_q;
        scratch_d   = scratch_q;
        count_d     = count_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        bcd_d       = bcd_q;
        seg_d       = seg_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (transfer) begin
                    bin_d       = in_value;
                    scratch_d   = '0;
                    count_d     = CW'(WIDTH);
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = CONVERT;
                end
            end
            CONVERT: begin
                // in_valid is ignored here; bcd/seg keep the previous result.
                bin_d     = bin_step;
                scratch_d = scratch_step;
                count_d   = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    bcd_d       = scratch_step;
                    seg_d       = seg_step;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge hz100) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath and output registers.
    always_ff @(posedge hz100) begin
        if (reset) begin
            bin_q       <= '0;
            scratch_q   <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            seg_q       <= '0;
        end else begin
            bin_q       <= bin_d;
            scratch_q   <= scratch_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            bcd_q       <= bcd_d;
            seg_q       <= seg_d;
        end
    end

endmodule

// File: tb/tb_sum_bcd_display.sv
`timescale 1ns/1ps
// tb_sum_bcd_display
//   Directed bench for sum_bcd_display. Two instances share the inputs: one
//   with leading-zero blanking, one without. Expected results come from a
//   decimal model and are queued when a value is handed over, then popped and
//   compared when the conversion completes.
module tb_sum_bcd_display;

    localparam int WIDTH  = 9;
    localparam int DIGITS = 3;

    logic                hz100 = 1'b0;
    logic                reset;
    logic                in_valid;
    logic [WIDTH-1:0]    in_value;

    logic                in_ready, busy, out_valid;
    logic [4*DIGITS-1:0] bcd;
    logic [8*DIGITS-1:0] seg;

    logic                nb_in_ready, nb_busy, nb_out_valid;
    logic [4*DIGITS-1:0] nb_bcd;
    logic [8*DIGITS-1:0] nb_seg;

    sum_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LEADING(1'b1)) u_dut (
        .hz100    (hz100),
        .reset    (reset),
        .in_valid (in_valid),
        .in_value (in_value),
        .in_ready (in_ready),
        .busy     (busy),
        .out_valid(out_valid),
        .bcd      (bcd),
        .seg      (seg)
    );

    sum_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LEADING(1'b0)) u_nb (
        .hz100    (hz100),
        .reset    (reset),
        .in_valid (in_valid),
        .in_value (in_value),
        .in_ready (nb_in_ready),
        .busy     (nb_busy),
        .out_valid(nb_out_valid),
        .bcd      (nb_bcd),
        .seg      (nb_seg)
    );

    always #5 hz100 = ~hz100;

    typedef struct {
        logic [11:0] bcd;
        logic [23:0] seg;
        logic [23:0] seg_nb;
    } exp_t;

    exp_t sb[$];
    exp_t prev;          // result the displays must be holding
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h3F;
            1: return 8'h06;
            2: return 8'h5B;
            3: return 8'h4F;
            4: return 8'h66;
            5: return 8'h6D;
            6: return 8'h7D;
            7: return 8'h07;
            8: return 8'h7F;
            9: return 8'h67;
            default: return 8'h00;
        endcase
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        int d2, d1, d0;
        d2 = (v / 100) % 10;
        d1 = (v / 10) % 10;
        d0 = v % 10;
        e.bcd    = {4'(d2), 4'(d1), 4'(d0)};
        e.seg_nb = {seg_of(d2), seg_of(d1), seg_of(d0)};
        e.seg    = {(d2 == 0) ? 8'h00 : seg_of(d2),
                    (d2 == 0 && d1 == 0) ? 8'h00 : seg_of(d1),
                    seg_of(d0)};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_bcd"},       32'(bcd),       32'd0);
        check({tag, "_seg"},       32'(seg),       32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_value = '0;
        repeat (2) @(posedge hz100);
        #1;
        reset = 1'b0;
        check_reset_values("reset");
        prev = '{bcd: '0, seg: '0, seg_nb: '0};
    endtask

    // Hand a value over on the next edge (edge 0 of its conversion).
    task automatic transfer(input logic [WIDTH-1:0] v);
        in_value = v;
        in_valid = 1'b1;
        sb.push_back(model(int'(v)));
        @(posedge hz100);
        #1;
        in_valid = 1'b0;
        in_value = WIDTH'($urandom);
        check("xfer_in_ready",  32'(in_ready),  32'd0);
        check("xfer_busy",      32'(busy),      32'd0);
        check("xfer_out_valid", 32'(out_valid), 32'd0);
        check("xfer_bcd_hold",  32'(bcd),       32'(prev.bcd));
    endtask

    // Walk edges 1..WIDTH of a conversion. pulse_at: drive a stray in_valid
    // sampled at that edge. reset_at: assert reset sampled at that edge.
    task automatic run_conv(input int pulse_at, input int reset_at);
        exp_t e;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        e = sb.pop_front();
        for (int k = 1; k <= WIDTH; k++) begin
            if (k == pulse_at) begin
                in_valid = 1'b1;
                in_value = 9'h0FF;
            end
            if (k == reset_at) reset = 1'b1;
            @(posedge hz100);
            #1;
            in_valid = 1'b0;
            if (k == reset_at) begin
                reset = 1'b0;
                check_reset_values("mid_reset");
                prev = '{bcd: '0, seg: '0, seg_nb: '0};
                return;
            end
            if (k < WIDTH) begin
                check("conv_busy",      32'(busy),      32'd1);
                check("conv_in_ready",  32'(in_ready),  32'd0);
                check("conv_out_valid", 32'(out_valid), 32'd0);
                check("conv_bcd_hold",  32'(bcd),       32'(prev.bcd));
                check("conv_seg_hold",  32'(seg),       32'(prev.seg));
            end else begin
                check("done_out_valid", 32'(out_valid), 32'd1);
                check("done_busy",      32'(busy),      32'd0);
                check("done_in_ready",  32'(in_ready),  32'd1);
                check("done_bcd",       32'(bcd),       32'(e.bcd));
                check("done_seg",       32'(seg),       32'(e.seg));
                check("done_nb_bcd",    32'(nb_bcd),    32'(e.bcd));
                check("done_nb_seg",    32'(nb_seg),    32'(e.seg_nb));
                prev = e;
            end
        end
    endtask

    task automatic idle_hold(input int n);
        repeat (n) begin
            @(posedge hz100);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_bcd",       32'(bcd),       32'(prev.bcd));
            check("hold_seg",       32'(seg),       32'(prev.seg));
        end
    endtask

    initial begin
        logic [8:0] sum;

        do_reset();

        // Zero: only the ones digit lights.
        transfer(9'h000);
        run_conv(0, 0);
        check("zero_seg", 32'(seg), 32'h00003F);

        // Full scale 511.
        transfer(9'h1FF);
        run_conv(0, 0);
        check("max_bcd", 32'(bcd), 32'h511);

        // Adder carry-out case: 0xFF + 0x01, ci=0.
        sum = 9'(8'hFF) + 9'(8'h01);
        transfer(sum);
        run_conv(0, 0);
        check("carry_bcd", 32'(bcd), 32'h256);

        // Single digit: blanking vs. no blanking.
        transfer(9'h009);
        run_conv(0, 0);
        check("nine_seg",    32'(seg),    32'h000067);
        check("nine_nb_seg", 32'(nb_seg), 32'h3F3F67);

        // 123 with a stray in_valid at edge 4, which must be ignored.
        transfer(9'h07B);
        run_conv(4, 0);
        check("ignored_bcd", 32'(bcd), 32'h123);

        // Back-to-back transfer straight out of DONE.
        transfer(9'h0FF);
        run_conv(0, 0);
        idle_hold(3);

        // Reset in the middle of a conversion, then a fresh conversion.
        transfer(9'h150);
        run_conv(0, 5);
        transfer(9'h1A4);
        run_conv(0, 0);

        // A few arbitrary values.
        for (int i = 0; i < 4; i++) begin
            transfer(WIDTH'($urandom_range(0, 511)));
            run_conv(0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
